// File: rtl/instr_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// instr_fetch_ctrl
//   Fetch sequencer for the instruction ROM. Owns the fetch PC (fpc) and
//   presents it directly as the ROM read address. Captures the combinational
//   ROM data into a small FIFO and hands {pc, instr} pairs to decode over a
//   valid/ready handshake. Execute can redirect fetch at any time. A redirect
//   flushes the FIFO. Fetch stops on a misaligned redirect target, or when fpc
//   runs past the end of the ROM.
//
// Ports
//   clk            in   1   clock, rising edge
//   reset          in   1   synchronous, active-high
//   fetch_en       in   1   1 = fetch allowed; 0 = hold fpc, FIFO still drains
//   instr_raddr    out  32  ROM byte address (= fpc)
//   instr_code     in   32  ROM data for instr_raddr, same cycle
//   redirect_valid in   1   flush and restart at redirect_pc
//   redirect_pc    in   32  redirect target byte address
//   out_valid      out  1   FIFO head valid
//   out_ready      in   1   decode accepts head
//   out_pc         out  32  head PC (0 when not valid)
//   out_instr      out  32  head instruction (0 when not valid)
//   misalign_err   out  1   sticky: last redirect target was misaligned
//   oob            out  1   sticky: fpc ran past the end of the ROM
// ----------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 32,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] instr_raddr,
    input  logic [31:0] instr_code,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        misalign_err,
    output logic        oob
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [31:0]      ROM_END = 32'(ROM_WORDS * 4);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_OOB      = 2'd1;
    localparam logic [1:0] S_MISALIGN = 2'd2;

    logic [1:0]       state;
    logic [31:0]      fpc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] buf_pc    [BUF_DEPTH];
    logic [31:0] buf_instr [BUF_DEPTH];

    logic in_rom;
    logic push;
    logic pop;

    assign in_rom      = (fpc < ROM_END);
    assign instr_raddr = fpc;

    // Full is judged on the pre-pop count, so a same-cycle pop never frees a
    // slot for a push. A redirect cycle never pushes: the ROM data belongs to
    // the path being abandoned.
    assign push = (state == S_RUN) && fetch_en && !redirect_valid &&
                  (count < DEPTH_C) && in_rom;
    assign pop  = out_valid && out_ready;

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? buf_pc[rd_ptr]    : 32'h0;
    assign out_instr = out_valid ? buf_instr[rd_ptr] : 32'h0;

    // Control state: PC, pointers, occupancy, FSM and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc          <= RESET_PC;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            state        <= S_RUN;
            misalign_err <= 1'b0;
            oob          <= 1'b0;
        end else if (redirect_valid) begin
            // Flush discards everything, including an entry popped this cycle.
            fpc    <= redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if (redirect_pc[1:0] != 2'b00) begin
                state        <= S_MISALIGN;
                misalign_err <= 1'b1;
            end else begin
                state        <= S_RUN;
                misalign_err <= 1'b0;
                oob          <= 1'b0;
            end
        end else begin
            if ((state == S_RUN) && !in_rom) begin
                state <= S_OOB;
                oob   <= 1'b1;
            end
            if (push) begin
                fpc    <= fpc + 32'd4;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: written only on push, never reset; occupancy gates the
    // outputs so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= fpc;
            buf_instr[wr_ptr] <= instr_code;
        end
    end

endmodule
